sub_shift: RTL and testbench



---
 rtl/sub_shift.sv | 121 ++++++++++++
 tb/tb_sub_shift.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_shift.sv
// sub_shift: iterative AES-128 SubBytes + ShiftRows round stage.
// A 128-bit state is accepted over a valid/ready handshake. LANES bytes per
// cycle go through shared forward S-boxes. The ShiftRows result is then held
// as a stable, registered word for the MixColumns stage.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream state valid
//   in_ready   stage can accept a state this cycle
//   in_state   128-bit state, byte s[i] at bits [127-8i -: 8]
//   out_valid  out_state holds a finished result
//   out_ready  downstream accepts the result
//   out_state  SubBytes then ShiftRows of the accepted state
module sub_shift #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   localparam int unsigned NCYC = 16 / LANES;
   localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [CW-1:0] ctr;
   logic [7:0]    work [16];
   logic [7:0]    lane_in  [LANES];
   logic [7:0]    lane_out [LANES];
   logic [3:0]    base;
   logic          accept;
   logic          last;

   assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign last     = (ctr == CW'(NCYC - 1));

   // The LANES S-boxes are shared: ctr selects which group of bytes feeds them.
   always_comb begin
      base = 4'(ctr) * 4'(LANES);
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_in[l]  = work[base + 4'(l)];
         lane_out[l] = SBOX[lane_in[l]];
      end
   end

   // ShiftRows is pure wiring: out column c, row r <- work column (c+r)%4, row r.
   always_comb begin
      out_state = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            out_state[127 - 8*(4*c + r) -: 8] = work[4*((c + r) % 4) + r];
         end
      end
   end

   // accept can only fire in IDLE or in DONE with out_ready, so it is
   // handled ahead of the state case; that covers the DONE->BUSY overlap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ctr       <= '0;
         out_valid <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) work[i] <= '0;
      end else if (accept) begin
         for (int unsigned i = 0; i < 16; i++) work[i] <= in_state[127 - 8*i -: 8];
         ctr       <= '0;
         out_valid <= 1'b0;
         state     <= BUSY;
      end else begin
         case (state)
            BUSY: begin
               for (int unsigned i = 0; i < 16; i++) begin
                  if (CW'(i / LANES) == ctr) work[i] <= lane_out[i % LANES];
               end
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_shift.sv
// tb_sub_shift: self-checking bench for sub_shift. The main instance uses
// LANES=4. Two more instances (LANES=8, 16) share the inputs and are checked
// for latency and data only. The reference S-box is computed from GF(2^8)
// inversion plus the affine map.
module tb_sub_shift;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         out_ready;
   logic [127:0] in_state;
   logic         in_ready, out_valid;
   logic [127:0] out_state;
   logic         in_ready_8, out_valid_8;
   logic [127:0] out_state_8;
   logic         in_ready_16, out_valid_16;
   logic [127:0] out_state_16;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc   = 0;
   logic [127:0] exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sub_shift #(.LANES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state));
   sub_shift #(.LANES(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_8), .in_state(in_state),
      .out_valid(out_valid_8), .out_ready(out_ready), .out_state(out_state_8));
   sub_shift #(.LANES(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_16), .in_state(in_state),
      .out_valid(out_valid_16), .out_ready(out_ready), .out_state(out_state_16));

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] d = {x, x};
      d = d << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] a);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);   // a^254 == a^-1, and 0 -> 0
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_model(input logic [127:0] s);
      logic [127:0] r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rr = 0; rr < 4; rr++) begin
            r[127 - 8*(4*c + rr) -: 8] = sbox_ref(s[127 - 8*(4*((c + rr) % 4) + rr) -: 8]);
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present st until accepted; push its expected result; returns one cycle after accept.
   task automatic send(input logic [127:0] st, input logic [127:0] expv, output bit ok);
      ok       = 1'b0;
      in_state = st;
      in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (in_ready) begin
            ok  = 1'b1;
            acc = cyc;
            exp_q.push_back(expv);
            break;
         end
         tick();
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Wait for out_valid; lat is cycles since the accept cycle, -1 on timeout.
   task automatic wait_out(output int lat);
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) begin
            lat = cyc - acc;
            break;
         end
         tick();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
      tick(); tick(); tick();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL reset_out_state got=%h exp=0", out_state); end
      rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_fips();
      bit ok;
      logic [127:0] e;
      out_ready = 1'b1;
      send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5, ok);
      total++; if (!ok) begin bad++; $display("FAIL fips_accept got=timeout exp=accept"); end
      for (int k = 1; k <= 4; k++) begin
         total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL fips_busy_c%0d got ready=%b valid=%b exp 0 0", k, in_ready, out_valid);
         end
         tick();
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fips_latency got valid=%b at cycle 5 exp=1", out_valid); end
      e = exp_q.pop_front();
      total++; if (out_state !== e) begin bad++; $display("FAIL fips_data got=%h exp=%h", out_state, e); end
      tick();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL fips_drain got valid=%b ready=%b exp 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_patterns();
      logic [127:0] pin [3];
      logic [127:0] pex [3];
      logic [127:0] e;
      bit ok;
      int lat;
      pin[0] = '0;  pex[0] = {16{8'h63}};
      pin[1] = '1;  pex[1] = {16{8'h16}};
      pin[2] = 128'h000102030405060708090a0b0c0d0e0f;
      pex[2] = 128'h636b6776_f201ab7b_30d777c5_fe7c6f2b;
      out_ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         send(pin[p], pex[p], ok);
         wait_out(lat);
         total++; if (lat != 5) begin bad++; $display("FAIL pattern%0d_latency got=%0d exp=5", p, lat); end
         e = exp_q.pop_front();
         total++; if (out_state !== e) begin bad++; $display("FAIL pattern%0d_data got=%h exp=%h", p, out_state, e); end
         tick();
      end
   endtask

   task automatic test_lanes();
      logic [127:0] pin [2];
      logic [127:0] pex [2];
      logic [127:0] g4, g8, g16;
      int l4, l8, l16, start;
      pin[0] = '0;  pex[0] = {16{8'h63}};
      pin[1] = '1;  pex[1] = {16{8'h16}};
      for (int p = 0; p < 2; p++) begin
         rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
         tick(); tick();
         rst_n = 1'b1;
         tick();
         in_state = pin[p]; in_valid = 1'b1;
         #1;
         total++; if ({in_ready, in_ready_8, in_ready_16} !== 3'b111) begin
            bad++; $display("FAIL lanes%0d_ready got=%b exp=111", p, {in_ready, in_ready_8, in_ready_16});
         end
         start = cyc;
         tick();
         in_valid = 1'b0;
         l4 = -1; l8 = -1; l16 = -1; g4 = 'x; g8 = 'x; g16 = 'x;
         for (int k = 0; k < 10; k++) begin
            if (out_valid && l4 < 0) begin l4 = cyc - start; g4 = out_state; end
            if (out_valid_8 && l8 < 0) begin l8 = cyc - start; g8 = out_state_8; end
            if (out_valid_16 && l16 < 0) begin l16 = cyc - start; g16 = out_state_16; end
            tick();
         end
         total++; if (l4 != 5) begin bad++; $display("FAIL lanes4_latency got=%0d exp=5", l4); end
         total++; if (l8 != 3) begin bad++; $display("FAIL lanes8_latency got=%0d exp=3", l8); end
         total++; if (l16 != 2) begin bad++; $display("FAIL lanes16_latency got=%0d exp=2", l16); end
         total++; if (g4 !== pex[p]) begin bad++; $display("FAIL lanes4_data got=%h exp=%h", g4, pex[p]); end
         total++; if (g8 !== pex[p]) begin bad++; $display("FAIL lanes8_data got=%h exp=%h", g8, pex[p]); end
         total++; if (g16 !== pex[p]) begin bad++; $display("FAIL lanes16_data got=%h exp=%h", g16, pex[p]); end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] a, b, hold, e;
      bit ok;
      int lat;
      a = rand128();
      b = rand128();
      out_ready = 1'b0;
      send(a, ref_model(a), ok);
      wait_out(lat);
      total++; if (lat != 5) begin bad++; $display("FAIL bp_latency got=%0d exp=5", lat); end
      hold = out_state;
      for (int k = 0; k < 10; k++) begin
         in_state = b; in_valid = 1'b1;
         #1;
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d got=%b exp=1", k, out_valid); end
         total++; if (out_state !== hold) begin bad++; $display("FAIL bp_stable_c%0d got=%h exp=%h", k, out_state, hold); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d got=%b exp=0", k, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      e = exp_q.pop_front();
      total++; if (out_state !== e) begin bad++; $display("FAIL bp_data_a got=%h exp=%h", out_state, e); end
      acc = cyc;
      exp_q.push_back(ref_model(b));
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_consumed got=%b exp=0", out_valid); end
      wait_out(lat);
      total++; if (lat != 5) begin bad++; $display("FAIL bp_b_latency got=%0d exp=5", lat); end
      e = exp_q.pop_front();
      total++; if (out_state !== e) begin bad++; $display("FAIL bp_data_b got=%h exp=%h", out_state, e); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [127:0] st [8];
      logic [127:0] e;
      int n_in = 0;
      int n_out = 0;
      int last_out = -1;
      for (int i = 0; i < 8; i++) st[i] = rand128();
      out_ready = 1'b1;
      for (int k = 0; k < 200 && n_out < 8; k++) begin
         if (out_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++; if (out_state !== e) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", n_out, out_state, e); end
            if (last_out >= 0) begin
               total++; if (cyc - last_out != 5) begin
                  bad++; $display("FAIL b2b_spacing%0d got=%0d exp=5", n_out, cyc - last_out);
               end
            end
            last_out = cyc;
            n_out++;
         end
         if (n_in < 8) begin
            in_state = st[n_in]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(st[n_in]));
            n_in++;
         end
         tick();
      end
      in_valid = 1'b0;
      total++; if (n_out != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", n_out); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_reset_midbusy();
      logic [127:0] a, c, e;
      bit ok;
      int lat;
      a = rand128();
      c = rand128();
      out_ready = 1'b1;
      send(a, ref_model(a), ok);
      tick();                               // now in BUSY cycle 2
      rst_n = 1'b0;
      void'(exp_q.pop_back());              // aborted state never produces output
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL midrst_state got=%h exp=0", out_state); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_low got=%b exp=0", in_ready); end
      rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
      send(c, ref_model(c), ok);
      wait_out(lat);
      total++; if (lat != 5) begin bad++; $display("FAIL midrst_latency got=%0d exp=5", lat); end
      e = exp_q.pop_front();
      total++; if (out_state !== e) begin bad++; $display("FAIL midrst_data got=%h exp=%h", out_state, e); end
      tick();
   endtask

   initial begin
      test_reset();
      test_fips();
      test_patterns();
      test_backpressure();
      test_back_to_back();
      test_reset_midbusy();
      test_lanes();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
